cpu_step_ctrl: RTL



---
 rtl/cpu_step_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_step_ctrl
//
// Board-level front end for the multi-cycle RISC-V CPU. Turns raw, bouncing
// push-buttons and a run switch into a clean clock-enable scheme on the board
// oscillator. The CPU sees one step_en pulse per state advance and a stretched,
// synchronous reset.
//
// Ports:
//   clk         board oscillator, all logic on the rising edge
//   rst_n       asynchronous active-low global reset
//   key_step_n  raw step button, active-low, asynchronous, bouncing
//   key_rst_n   raw CPU-reset button, active-low, asynchronous, bouncing
//   sw_run      raw run switch (1 = free-run), asynchronous, bouncing
//   step_en     one-cycle pulse; the CPU advances one state per pulse
//   cpu_rst_n   active-low CPU reset, synchronous to clk
//   step_cnt    step_en pulses since the last CPU reset (wraps at 16 bits)
//   run_active  debounced run-mode indicator
// -----------------------------------------------------------------------------
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 25000000,
  parameter int RST_HOLD        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_step_n,
  input  logic        key_rst_n,
  input  logic        sw_run,
  output logic        step_en,
  output logic        cpu_rst_n,
  output logic [15:0] step_cnt,
  output logic        run_active
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W  = $clog2(RUN_DIV);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(RUN_DIV - 1);
  // step_en is registered, so it is launched one count early to be high
  // exactly while the divider sits at RUN_DIV-1.
  localparam logic [DIV_W-1:0]  DIV_PRE  = DIV_W'(RUN_DIV - 2);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD - 1);

  // Bit order for the per-input vectors: [2] sw_run, [1] key_rst_n, [0] key_step_n.
  // Idle levels: switch off, keys released.
  localparam logic [2:0] IDLE_LEVEL = 3'b011;

  typedef enum logic [1:0] {
    R_HOLD,
    R_WAIT_REL,
    R_IDLE
  } rst_state_t;

  typedef enum logic {
    S_MANUAL,
    S_RUN
  } step_state_t;

  logic [2:0]      raw_in;
  logic [2:0]      sync_q1;
  logic [2:0]      sync_q2;
  logic [2:0]      stable;
  logic [DB_W-1:0] db_cnt [3];
  logic [1:0]      prev_key;

  logic            step_press;
  logic            rst_press;
  logic            key_rst_held;
  logic            sw_on;
  logic            rst_entry;
  logic            step_ok;

  rst_state_t      rst_state;
  step_state_t     step_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [15:0]       step_cnt_q;

  assign raw_in = {sw_run, key_rst_n, key_step_n};

  // Two-flop synchronizers for the asynchronous board inputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= IDLE_LEVEL;
      sync_q2 <= IDLE_LEVEL;
    end else begin
      sync_q1 <= raw_in;
      sync_q2 <= sync_q1;
    end
  end

  // Debouncers: a level is accepted only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement with the current stable level; any agreement
  // restarts the count, so short glitches never propagate.
  // NOTE: the small counter array is reset explicitly element by element;
  // it is plain flops, not a RAM, so a reset costs nothing and keeps the
  // post-reset state deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= IDLE_LEVEL;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_q2[i] != stable[i]) begin
          if (db_cnt[i] == DB_MAX) begin
            stable[i] <= sync_q2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Previous debounced key levels for falling-edge (press) detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_key <= 2'b11;
    else        prev_key <= stable[1:0];
  end

  assign step_press   = prev_key[0] & ~stable[0];
  assign rst_press    = prev_key[1] & ~stable[1];
  assign key_rst_held = ~stable[1];
  assign sw_on        = stable[2];

  // A reset press in R_IDLE restarts the CPU reset sequence and beats any
  // step request arriving in the same cycle.
  assign rst_entry = (rst_state == R_IDLE) && rst_press;
  assign step_ok   = (rst_state == R_IDLE) && cpu_rst_n && !rst_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_state  <= R_HOLD;
      hold_cnt   <= '0;
      cpu_rst_n  <= 1'b0;
      step_state <= S_MANUAL;
      div_cnt    <= '0;
      step_en    <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      step_en <= 1'b0;

      // CPU reset sequencer.
      case (rst_state)
        R_HOLD: begin
          if (hold_cnt == HOLD_MAX) begin
            rst_state <= R_WAIT_REL;
            // With the key already released the CPU leaves reset right after
            // the hold time instead of one wait cycle later.
            cpu_rst_n <= ~key_rst_held;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        R_WAIT_REL: begin
          if (!key_rst_held) begin
            rst_state <= R_IDLE;
            cpu_rst_n <= 1'b1;
          end else begin
            cpu_rst_n <= 1'b0;
          end
        end
        R_IDLE: begin
          if (rst_press) begin
            rst_state <= R_HOLD;
            hold_cnt  <= '0;
            cpu_rst_n <= 1'b0;
          end
        end
        default: begin
          rst_state <= R_HOLD;
          hold_cnt  <= '0;
          cpu_rst_n <= 1'b0;
        end
      endcase

      // Step source: manual presses or the free-running divider.
      case (step_state)
        S_MANUAL: begin
          if (sw_on) begin
            step_state <= S_RUN;
            div_cnt    <= '0;
          end else if (step_ok && step_press) begin
            step_en <= 1'b1;
          end
        end
        S_RUN: begin
          if (!sw_on) begin
            step_state <= S_MANUAL;
          end else if (rst_state == R_IDLE) begin
            // The divider is frozen while the CPU is held in reset.
            div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + DIV_W'(1);
            if (step_ok && div_cnt == DIV_PRE) step_en <= 1'b1;
          end
        end
      endcase

      if (rst_entry) div_cnt <= '0;

      if (rst_entry)    step_cnt_q <= '0;
      else if (step_en) step_cnt_q <= step_cnt_q + 16'd1;
    end
  end

  assign step_cnt   = step_cnt_q;
  assign run_active = (step_state == S_RUN);

endmodule
